onchip_mem_pixel_packer: RTL

//  Sits directly downstream of the on-chip memory read FIFO. Pops 288-bit entries {256b data, 32b byte-valid mask},

---
 rtl/onchip_mem_pixel_packer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/onchip_mem_pixel_packer.sv
// Purpose: pops {data,mask} entries from the on-chip memory read FIFO, drops invalid bytes, repacks into BPP-byte pixels.
// Latency: read_req at N -> entry at N+1 -> pixel bytes visible (pix_valid_out possible) at N+2.
// Backpressure: valid/ready on pixel side; one outstanding FIFO read, gated on buffer room and remaining pixel demand.
module onchip_mem_pixel_packer #(
    parameter int BPP = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_in,
    input  logic [23:0]      pixel_count_in,
    output logic             busy_out,
    output logic             done_out,
    output logic             read_req_out,
    input  logic             data_ready_in,
    input  logic [287:0]     read_data_in,
    input  logic             read_data_valid_in,
    output logic [8*BPP-1:0] pix_data_out,
    output logic             pix_valid_out,
    input  logic             pix_ready_in,
    output logic             pix_sop_out,
    output logic             pix_eop_out,
    output logic             err_out
);

    localparam logic [6:0]  BPP_B  = 7'(BPP);
    localparam logic [25:0] BPP_W  = 26'(BPP);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;

    logic [511:0] r_buf;          // byte 0 of the stream lives in [7:0]
    logic [6:0]   r_byte_cnt;
    logic         r_pending;
    logic         r_first;        // next transferred pixel is the segment's first
    logic         r_done;
    logic         r_err;
    logic [23:0]  r_pixels_left;

    logic         w_run;
    logic         w_xfer;
    logic         w_last;
    logic         w_append;
    logic         w_stray;
    logic [25:0]  w_bytes_needed;
    logic [5:0]   w_popcnt;
    logic [4:0]   w_first_idx;
    logic         w_found;
    logic [255:0] w_ext;
    logic [6:0]   w_cnt_sh;
    logic [6:0]   w_cnt_nxt;
    logic [511:0] w_buf_sh;
    logic [511:0] w_buf_nxt;

    assign w_run          = (r_state == ST_RUN);
    assign w_bytes_needed = {2'b00, r_pixels_left} * BPP_W;

    // Fetch only while there is room for a full entry and the buffer cannot yet cover the remaining pixels,
    // so nothing is ever in flight when the last pixel leaves.
    assign read_req_out   = w_run & data_ready_in & ~r_pending & (r_byte_cnt <= 7'd32)
                          & ({19'd0, r_byte_cnt} < w_bytes_needed);

    assign pix_valid_out  = w_run & (r_byte_cnt >= BPP_B) & (r_pixels_left != 24'd0);
    assign pix_data_out   = r_buf[8*BPP-1:0];
    assign pix_sop_out    = pix_valid_out & r_first;
    assign pix_eop_out    = pix_valid_out & (r_pixels_left == 24'd1);
    assign busy_out       = w_run;
    assign done_out       = r_done;
    assign err_out        = r_err;

    assign w_xfer         = pix_valid_out & pix_ready_in;
    assign w_last         = w_xfer & (r_pixels_left == 24'd1);
    assign w_append       = w_run & read_data_valid_in & r_pending;
    assign w_stray        = w_run & read_data_valid_in & ~r_pending;

    // Count valid bytes and locate the lowest-index valid byte (mask bit 31-i flags byte i).
    always_comb begin
        w_popcnt    = '0;
        w_first_idx = '0;
        w_found     = 1'b0;
        for (int i = 0; i < 32; i++) begin
            w_popcnt = w_popcnt + {5'd0, read_data_in[31-i]};
            if (read_data_in[31-i] && !w_found) begin
                w_first_idx = 5'(i);
                w_found     = 1'b1;
            end
        end
    end

    // Surviving bytes right-aligned: popcount bytes starting at the first valid byte, upper bits zeroed
    // so they can be OR-ed into the empty region of the buffer.
    assign w_ext = (read_data_in[287:32] >> {w_first_idx, 3'b000})
                 & ~({256{1'b1}} << {w_popcnt, 3'b000});

    // Drain first, then append above whatever remains, so both happen in one cycle.
    always_comb begin
        w_buf_sh  = r_buf;
        w_cnt_sh  = r_byte_cnt;
        if (w_xfer) begin
            w_buf_sh = r_buf >> (8*BPP);
            w_cnt_sh = r_byte_cnt - BPP_B;
        end
        w_buf_nxt = w_buf_sh;
        w_cnt_nxt = w_cnt_sh;
        if (w_append) begin
            w_buf_nxt = w_buf_sh | ({256'd0, w_ext} << {w_cnt_sh, 3'b000});
            w_cnt_nxt = w_cnt_sh + {1'b0, w_popcnt};
        end
    end

    // Next-state: a non-empty start enters RUN, the last pixel transfer returns to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start_in && (pixel_count_in != 24'd0)) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Byte buffer, read tracking, pixel counter and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf         <= '0;
            r_byte_cnt    <= '0;
            r_pending     <= 1'b0;
            r_first       <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_pixels_left <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_state == ST_IDLE) begin
                // Entries arriving while idle are dropped without flagging.
                if (start_in) begin
                    r_pixels_left <= pixel_count_in;
                    r_buf         <= '0;
                    r_byte_cnt    <= '0;
                    r_pending     <= 1'b0;
                    r_err         <= 1'b0;
                    r_first       <= 1'b1;
                    r_done        <= (pixel_count_in == 24'd0);
                end
            end else begin
                r_buf      <= w_buf_nxt;
                r_byte_cnt <= w_cnt_nxt;
                if (read_req_out)  r_pending <= 1'b1;
                else if (w_append) r_pending <= 1'b0;
                if (w_stray) r_err <= 1'b1;
                if (w_xfer) begin
                    r_pixels_left <= r_pixels_left - 24'd1;
                    r_first       <= 1'b0;
                end
                if (w_last) begin
                    // Residual bytes shorter than a pixel are thrown away.
                    r_done     <= 1'b1;
                    r_buf      <= '0;
                    r_byte_cnt <= '0;
                end
            end
        end
    end

endmodule
